// File: rtl/frame_update_scheduler_pkg.sv
// Shared types and VGA timing constants for the
// per-frame update scheduler.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    DONE
  } sched_state_t;

  localparam int H_TOTAL      = 1040;
  localparam int V_BACK_PORCH = 23;

  localparam int DEF_WINDOW_CYCLES =
    H_TOTAL * V_BACK_PORCH;

endpackage

// File: rtl/frame_update_scheduler_if.sv
// Request/acknowledge bundle between the scheduler
// and the game-logic update tasks.
interface frame_update_scheduler_if #(
  parameter int NUM_TASKS = 4
);

  logic [NUM_TASKS-1:0] task_req;
  logic [NUM_TASKS-1:0] task_ack;

  modport master (
    output task_req,
    input  task_ack
  );

  modport slave (
    input  task_req,
    output task_ack
  );

endinterface

// File: rtl/frame_update_scheduler_sync_edge_detect.sv
// Registers active-low vsync and flags its falling edge.
// Resets high so no edge appears on reset release.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_n,
  output logic fall
);

  logic vs_q;
  logic vs_d;

  always_comb begin
    vs_d = sig_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_q <= 1'b1;
    else        vs_q <= vs_d;
  end

  assign fall = vs_q & ~sig_n;

endmodule

// File: rtl/frame_update_scheduler.sv
// Runs the prioritised per-frame update tasks inside
// vertical blanking, with a cycle budget and overrun flag.
module frame_update_scheduler
  import frame_sched_pkg::*;
#(
  parameter int NUM_TASKS     = 4,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int FRAME_DIV     = 1
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Enable,
  input  logic        vSync_n,
  input  logic        overrun_clear,
  frame_update_scheduler_if.master tif,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  output logic [15:0] frame_count
);

  localparam int IW = $clog2(NUM_TASKS);
  localparam int WW = $clog2(WINDOW_CYCLES);

  localparam logic [IW-1:0] LAST =
    IW'(NUM_TASKS - 1);
  localparam logic [WW-1:0] WIN_LOAD =
    WW'(WINDOW_CYCLES - 1);
  localparam logic [7:0] DIV_LAST =
    8'(FRAME_DIV - 1);

  sched_state_t state_q, state_d;

  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        idx_nxt;
  logic [NUM_TASKS-1:0] req_q, req_d;
  logic                 busy_q, busy_d;
  logic                 fd_q, fd_d;
  logic                 ovr_q, ovr_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [WW-1:0]        win_q, win_d;
  logic [7:0]           div_q, div_d;
  logic                 frame_start;
  logic                 eligible;
  logic                 ack_hit;

  sync_edge_detect u_edge (
    .clk   (Clock),
    .rst_n (Reset_n),
    .sig_n (vSync_n),
    .fall  (frame_start)
  );

  assign eligible = (div_q == 8'd0);
  assign ack_hit  = tif.task_ack[idx_q];
  assign idx_nxt  = idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    req_d   = req_q;
    busy_d  = busy_q;
    fd_d    = 1'b0;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    div_d   = div_q;

    if (frame_start) begin
      div_d = (div_q == DIV_LAST) ?
              8'd0 : div_q + 8'd1;
    end

    if (busy_q && win_q != '0) begin
      win_d = win_q - WW'(1);
    end

    // Set beats clear when both land together.
    if (overrun_clear) ovr_d = 1'b0;
    if (frame_start && busy_q) ovr_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (frame_start && Enable && eligible) begin
          state_d = ISSUE;
          win_d   = WIN_LOAD;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ISSUE: begin
        req_d   = NUM_TASKS'(1) << idx_q;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_hit) begin
          if (idx_q == LAST) begin
            req_d   = '0;
            busy_d  = 1'b0;
            fd_d    = 1'b1;
            cnt_d   = cnt_q + 16'd1;
            state_d = DONE;
          end else begin
            idx_d = idx_nxt;
            req_d = NUM_TASKS'(1) << idx_nxt;
          end
        end else if (win_q == '0) begin
          req_d   = '0;
          busy_d  = 1'b0;
          ovr_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      req_q   <= '0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= 16'd0;
      win_q   <= '0;
      div_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      div_q   <= div_d;
    end
  end

  assign tif.task_req = req_q;
  assign busy         = busy_q;
  assign frame_done   = fd_q;
  assign overrun      = ovr_q;
  assign frame_count  = cnt_q;

endmodule
